// File: rtl/sd_sector_writer_if.sv
// rtl/sd_sector_writer_if.sv - byte-stream input and sd_controller write-port bundles
// master drives the forward signals; slave returns the handshake/status signals.

interface sd_byte_stream_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;

  modport master (output in_data, in_valid, flush, input in_ready);
  modport slave  (input in_data, in_valid, flush, output in_ready);
endinterface

interface sd_wr_port_if;
  logic        sd_ready;
  logic        sd_ready_for_next_byte;
  logic        sd_wr;
  logic [7:0]  sd_din;
  logic [31:0] sd_addr;

  modport master (output sd_wr, sd_din, sd_addr, input sd_ready, sd_ready_for_next_byte);
  modport slave  (input sd_wr, sd_din, sd_addr, output sd_ready, sd_ready_for_next_byte);
endinterface

// File: rtl/sd_sector_writer.sv
// rtl/sd_sector_writer.sv - buffers one sector of stream bytes and writes it through sd_controller
// Fill (or flush-pad) a sector RAM, then hand bytes out on each ready_for_next_byte rising edge.

module sd_sector_writer #(
  parameter int          SECTOR_BYTES = 512,
  parameter logic [31:0] START_ADDR   = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP    = 32'd512,
  parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
  input  logic              clk_25mhz,
  input  logic              rst,
  sd_byte_stream_if.slave   i_stream,
  sd_wr_port_if.master      o_sd,
  output logic              o_busy,
  output logic [15:0]       o_sectors_written,
  output logic              o_done_pulse
);

  localparam int            AW     = $clog2(SECTOR_BYTES);
  localparam logic [AW:0]   C_LAST = (AW+1)'(SECTOR_BYTES - 1);

  typedef enum logic [2:0] {S_FILL, S_PAD, S_WAIT_RDY, S_SEND, S_WAIT_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_buf [SECTOR_BYTES];
  logic [AW:0] r_fill_cnt;
  logic [AW:0] r_rd_ptr;
  logic        r_sd_wr;
  logic [7:0]  r_sd_din;
  logic [31:0] r_addr;
  logic [15:0] r_count;
  logic        r_done;
  logic        r_rfnb_prev;
  logic        r_seen_low;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_edge;
  logic          w_start;
  logic          w_complete;
  logic          w_we;
  logic [7:0]    w_wdata;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;

  assign w_accept   = i_stream.in_valid && (r_state == S_FILL);
  assign w_edge     = o_sd.sd_ready_for_next_byte && !r_rfnb_prev;
  assign w_start    = (r_state == S_WAIT_RDY) && o_sd.sd_ready;
  // Completion needs the controller to have gone busy at least once since the strobe.
  assign w_complete = (r_state == S_WAIT_DONE) && o_sd.sd_ready && r_seen_low;

  always_ff @(posedge clk_25mhz) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL: begin
        if (w_accept && (r_fill_cnt == C_LAST))
          w_next = S_WAIT_RDY;
        else if (i_stream.flush && (w_accept || (r_fill_cnt != '0)))
          w_next = S_PAD;
      end
      S_PAD:       if (r_fill_cnt == C_LAST) w_next = S_WAIT_RDY;
      S_WAIT_RDY:  if (o_sd.sd_ready) w_next = S_SEND;
      S_SEND:      if (w_edge && (r_rd_ptr == C_LAST)) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (w_complete) w_next = S_FILL;
      default:     w_next = S_FILL;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == S_FILL);
    w_we       = w_accept || (r_state == S_PAD);
    w_wdata    = (r_state == S_PAD) ? PAD_BYTE : i_stream.in_data;
    w_rd_en    = w_start || ((r_state == S_SEND) && w_edge);
    w_rd_addr  = '0;
    if (r_state == S_SEND) w_rd_addr = r_rd_ptr[AW-1:0] + 1'b1;
  end

  always_ff @(posedge clk_25mhz) begin
    if (w_we) r_buf[r_fill_cnt[AW-1:0]] <= w_wdata;
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      r_fill_cnt  <= '0;
      r_rd_ptr    <= '0;
      r_sd_wr     <= 1'b0;
      r_sd_din    <= 8'h00;
      r_addr      <= START_ADDR;
      r_count     <= 16'd0;
      r_done      <= 1'b0;
      r_rfnb_prev <= 1'b0;
      r_seen_low  <= 1'b0;
    end else begin
      r_rfnb_prev <= o_sd.sd_ready_for_next_byte;
      r_sd_wr     <= w_start;
      r_done      <= w_complete;
      if (w_we)            r_fill_cnt <= r_fill_cnt + 1'b1;
      else if (w_complete) r_fill_cnt <= '0;
      // The read lands one cycle after the edge and is held until the next edge.
      if (w_rd_en) r_sd_din <= r_buf[w_rd_addr];
      if (w_start) begin
        r_rd_ptr   <= '0;
        r_seen_low <= 1'b0;
      end else begin
        if ((r_state == S_SEND) && w_edge) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (!o_sd.sd_ready) r_seen_low <= 1'b1;
      end
      if (w_complete) begin
        r_addr  <= r_addr + ADDR_STEP;
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign i_stream.in_ready = w_in_ready;
  assign o_busy            = !w_in_ready;
  assign o_sd.sd_wr        = r_sd_wr;
  assign o_sd.sd_din       = r_sd_din;
  assign o_sd.sd_addr      = r_addr;
  assign o_sectors_written = r_count;
  assign o_done_pulse      = r_done;

endmodule

// File: tb/tb_sd_sector_writer.sv
// tb/tb_sd_sector_writer.sv - self-checking bench for sd_sector_writer
// A stream-level byte queue predicts every byte and address the sd_controller model must see.
`timescale 1ns/1ps

module tb_sd_sector_writer;

  logic clk_25mhz = 1'b0;
  logic rst       = 1'b1;
  always #20 clk_25mhz = ~clk_25mhz;

  sd_byte_stream_if u_stream ();
  sd_wr_port_if     u_sd ();
  logic        busy;
  logic [15:0] sectors_written;
  logic        done_pulse;

  sd_sector_writer u_dut (
    .clk_25mhz         (clk_25mhz),
    .rst               (rst),
    .i_stream          (u_stream.slave),
    .o_sd              (u_sd.master),
    .o_busy            (busy),
    .o_sectors_written (sectors_written),
    .o_done_pulse      (done_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: queue of bytes the controller must receive, in order.
  logic [7:0]  exp_q [$];
  logic [31:0] wr_addr_log [$];
  int          mf = 0;
  int          model_done = 0;
  int          wr_total = 0;
  int          sec_bytes = 0;
  int          last_wr_cyc = 0;
  int          cyc = 0;
  logic        in_xfer = 1'b0;
  logic        prev_sd_ready = 1'b1;

  // sd_controller model
  logic [7:0] cap [512];
  int         pulse_cnt = 0;
  int         bfm_st = 0;
  int         bfm_t = 0;
  int         hold_cnt = 0;

  initial forever begin
    @(posedge clk_25mhz);
    cyc = cyc + 1;
  end

  initial begin
    u_sd.sd_ready = 1'b1;
    u_sd.sd_ready_for_next_byte = 1'b0;
    forever begin
      @(posedge clk_25mhz); #1;
      u_sd.sd_ready_for_next_byte = 1'b0;
      if (rst) begin
        bfm_st = 0;
        pulse_cnt = 0;
        u_sd.sd_ready = 1'b1;
      end else begin
        case (bfm_st)
          0: begin
            if (hold_cnt > 0) begin
              hold_cnt--;
              u_sd.sd_ready = 1'b0;
            end else begin
              u_sd.sd_ready = 1'b1;
            end
            if (u_sd.sd_wr) begin
              bfm_st = 1;
              bfm_t = 0;
              pulse_cnt = 0;
              u_sd.sd_ready = 1'b0;
            end
          end
          1: begin
            bfm_t++;
            if (bfm_t == 16) begin
              bfm_t = 0;
              if (pulse_cnt < 512) begin
                u_sd.sd_ready_for_next_byte = 1'b1;
                cap[pulse_cnt] = u_sd.sd_din;
                pulse_cnt++;
              end else begin
                bfm_st = 2;
              end
            end
          end
          default: begin
            u_sd.sd_ready = 1'b1;
            bfm_st = 0;
          end
        endcase
      end
    end
  end

  // Compare process
  initial forever begin
    @(negedge clk_25mhz);
    if (rst) begin
      exp_q.delete();
      wr_addr_log.delete();
      model_done = 0;
      in_xfer = 1'b0;
      sec_bytes = 0;
    end else begin
      if (done_pulse) begin
        chk("done_count", 32'(sectors_written), 32'(model_done + 1));
        chk("done_addr", u_sd.sd_addr, 32'((model_done + 1) * 512));
        chk("sector_len", 32'(sec_bytes), 32'd512);
        chk("done_while_xfer", 32'(in_xfer), 32'd1);
        in_xfer = 1'b0;
        model_done++;
      end
      if (u_sd.sd_wr) begin
        chk("wr_addr", u_sd.sd_addr, 32'(model_done * 512));
        chk("wr_after_ready", 32'(prev_sd_ready), 32'd1);
        chk("wr_not_overlapped", 32'(in_xfer), 32'd0);
        wr_addr_log.push_back(u_sd.sd_addr);
        in_xfer = 1'b1;
        sec_bytes = 0;
        wr_total++;
        last_wr_cyc = cyc;
      end
      if (in_xfer) begin
        chk("in_ready_xfer", 32'(u_stream.in_ready), 32'd0);
        chk("busy_xfer", 32'(busy), 32'd1);
      end
      if (u_sd.sd_ready_for_next_byte) begin
        if (exp_q.size() == 0) chk("byte_underflow", 32'd1, 32'd0);
        else chk("sd_din", 32'(u_sd.sd_din), 32'(exp_q.pop_front()));
        sec_bytes++;
      end
    end
    prev_sd_ready = u_sd.sd_ready;
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic send_byte(input logic [7:0] b, input logic fl);
    int t = 0;
    u_stream.in_data = b;
    u_stream.in_valid = 1'b1;
    u_stream.flush = fl;
    @(negedge clk_25mhz);
    while (!u_stream.in_ready && t < 20000) begin
      @(negedge clk_25mhz);
      t++;
    end
    if (!u_stream.in_ready) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk_25mhz); #1;
    u_stream.in_valid = 1'b0;
    u_stream.flush = 1'b0;
    exp_q.push_back(b);
    mf++;
    if (mf == 512) mf = 0;
    else if (fl) begin
      for (int i = mf; i < 512; i++) exp_q.push_back(8'h00);
      mf = 0;
    end
  endtask

  task automatic pulse_flush();
    u_stream.flush = 1'b1;
    @(posedge clk_25mhz); #1;
    u_stream.flush = 1'b0;
    if (mf > 0) begin
      for (int i = mf; i < 512; i++) exp_q.push_back(8'h00);
      mf = 0;
    end
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (model_done < n && t < 20000) begin
      @(posedge clk_25mhz);
      t++;
    end
    chk("wait_done_timeout", 32'(model_done >= n), 32'd1);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_25mhz);
    rst = 1'b1;
    @(negedge clk_25mhz);
    chk("rst_sd_wr", 32'(u_sd.sd_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(u_stream.in_ready), 32'd1);
    chk("rst_sd_addr", u_sd.sd_addr, 32'd0);
    chk("rst_sd_din", 32'(u_sd.sd_din), 32'd0);
    chk("rst_count", 32'(sectors_written), 32'd0);
    chk("rst_done", 32'(done_pulse), 32'd0);
    mf = 0;
    #5 rst = 1'b0;
    @(posedge clk_25mhz); #1;
  endtask

  initial begin
    int t;
    int w0;
    int t_fill;
    u_stream.in_data = 8'h00;
    u_stream.in_valid = 1'b0;
    u_stream.flush = 1'b0;
    repeat (3) @(posedge clk_25mhz);
    do_reset();

    // 1: 0..255,0..255
    for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b0);
    wait_done(1);
    chk("t1_cap0", 32'(cap[0]), 32'h00);
    chk("t1_cap255", 32'(cap[255]), 32'hFF);
    chk("t1_cap256", 32'(cap[256]), 32'h00);
    chk("t1_cap511", 32'(cap[511]), 32'hFF);
    chk("t1_count", 32'(sectors_written), 32'd1);
    chk("t1_addr", u_sd.sd_addr, 32'd512);
    chk("t1_writes", 32'(wr_total), 32'd1);

    // 2: A0..A9 then flush pads with 00
    for (int i = 0; i < 10; i++) send_byte(8'(8'hA0 + i), 1'b0);
    pulse_flush();
    @(negedge clk_25mhz);
    chk("t2_pad_in_ready", 32'(u_stream.in_ready), 32'd0);
    @(posedge clk_25mhz); #1;
    wait_done(2);
    chk("t2_cap0", 32'(cap[0]), 32'hA0);
    chk("t2_cap9", 32'(cap[9]), 32'hA9);
    chk("t2_cap10", 32'(cap[10]), 32'h00);
    chk("t2_cap511", 32'(cap[511]), 32'h00);
    chk("t2_addr", u_sd.sd_addr, 32'd1024);

    // 3: flush coincident with the 512th byte
    for (int i = 0; i < 511; i++) send_byte(8'(i) ^ 8'h5A, 1'b0);
    send_byte(8'hC3, 1'b1);
    wait_done(3);
    chk("t3_cap0", 32'(cap[0]), 32'h5A);
    chk("t3_cap511", 32'(cap[511]), 32'hC3);
    chk("t3_count", 32'(sectors_written), 32'd3);

    // 4: controller held not-ready while the sector waits
    @(negedge clk_25mhz);
    hold_cnt = 620;
    @(posedge clk_25mhz); #1;
    for (int i = 0; i < 512; i++) send_byte(8'(i * 3), 1'b0);
    t_fill = cyc;
    wait_done(4);
    chk("t4_hold_delay", 32'((last_wr_cyc - t_fill) >= 100), 32'd1);
    chk("t4_addr", u_sd.sd_addr, 32'd2048);

    // 5: reset after 200 bytes have been sent
    for (int i = 0; i < 512; i++) send_byte(~8'(i), 1'b0);
    t = 0;
    while (pulse_cnt < 200 && t < 20000) begin
      @(posedge clk_25mhz);
      t++;
    end
    chk("t5_reach_200", 32'(pulse_cnt >= 200), 32'd1);
    #1;
    do_reset();

    // 6: three back-to-back sectors from addr 0, then an empty flush
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 512; i++) send_byte(8'(i * 7 + s), 1'b0);
    wait_done(3);
    chk("t6_count", 32'(sectors_written), 32'd3);
    chk("t6_addr", u_sd.sd_addr, 32'd1536);
    chk("t6_nwr", 32'(wr_addr_log.size()), 32'd3);
    if (wr_addr_log.size() == 3) begin
      chk("t6_wr0", wr_addr_log[0], 32'd0);
      chk("t6_wr1", wr_addr_log[1], 32'd512);
      chk("t6_wr2", wr_addr_log[2], 32'd1024);
    end
    w0 = wr_total;
    pulse_flush();
    repeat (60) @(posedge clk_25mhz);
    #1;
    chk("t6_empty_flush_nowr", 32'(wr_total), 32'(w0));
    chk("t6_empty_flush_busy", 32'(busy), 32'd0);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
